regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter that owns the single write port of the 32×32 register file, which has two read ports, one write port and register 0 hardwired to zero. It merges two result sources into one `RegWrite` per cycle:
- **Source A:** ALU, single-cycle, takes priority.
- **Source B:** load unit, buffered in a small FIFO.

It also publishes a pending-write mask so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- `DEPTH`, 4, load-result FIFO entries (power of two, ≥2)
- `DATA_W`, 32, register data width
- `REG_AW`, 5, register address width

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `AValid`  in  1  ALU result valid
- `AReady`  out  1  ALU result accepted this cycle when high with `AValid`
- `AReg`  in  `REG_AW`  ALU destination register
- `AData`  in  `DATA_W`  ALU result
- `BValid`  in  1  load result valid
- `BReady`  out  1  load result accepted when high with `BValid`
- `BReg`  in  `REG_AW`  load destination register
- `BData`  in  `DATA_W`  load data
- `WriteRegister`  out  `REG_AW`  to regfile write address
- `WriteData`  out  `DATA_W`  to regfile write data
- `RegWrite`  out  1  to regfile write enable
- `Pending`  out  32  bit r set while a write to r is queued or in the output stage
- `Count`  out  clog2(`DEPTH`+1)  FIFO occupancy

## Operation
- **Acceptance:**
  - `BReady` = !full.
  - `AReady` = !full AND !QMask[`AReg`]. QMask is the OR of the destinations of valid FIFO entries.
  - A is therefore held off while an older load to the same register is still queued, which prevents write-after-write reordering.
- **Write-port selection, in priority order each cycle:**
  1. A accepted → write A.
  2. FIFO non-empty → dequeue head and write it.
  3. B accepted with FIFO empty and no A → bypass B straight to the output stage; it is not enqueued.
  4. Otherwise no write.
- **Enqueue:**
  - An accepted B not bypassed is enqueued behind existing entries, preserving order.
  - Enqueue and dequeue in the same cycle leave `Count` unchanged.
- **Register 0:**
  - A or B with destination 0 is accepted normally but discarded.
  - It produces no `RegWrite`, is never enqueued, and `Pending[0]` is always 0.
- **Output stage:**
  - `WriteRegister`, `WriteData` and `RegWrite` are registered.
  - On a no-write cycle `RegWrite`=0 and the address/data outputs hold their last values.
- **Pending:** `Pending` = QMask OR (`RegWrite` ? onehot(`WriteRegister`) : 0). It is combinational from state.
- **Full FIFO:** `AReady`=0 and `BReady`=0; the head drains one entry per cycle until not full.

## Timing
- **Reset values:**
  - `RegWrite`=0, `WriteRegister`=0, `WriteData`=0, `Count`=0, `Pending`=0.
  - `AReady`=1 and `BReady`=1 (FIFO empty).
  - Reset asserted mid-operation discards all queued entries and any in-flight output write immediately (asynchronous).
- **Latency and throughput:**
  - Handshake at edge N → `RegWrite` high during cycle N+1.
  - Regfile commits at edge N+1; the value is readable after edge N+1.
  - Throughput is one write per cycle.
- **Handshake rules:**
  - `AReady` and `BReady` are combinational from state and `AReg` only; they never depend on `AValid` or `BValid`.
  - A source may change its payload only after acceptance.
- **Simultaneous A and B:** A writes, B is enqueued. Under continuous A traffic the queued load is written only once the FIFO fills and A is blocked, or when A is idle.
- **Wrap-around:** read and write pointers wrap modulo `DEPTH`. Full/empty are distinguished by the pointer extra bit.

## Structure
- **Package `regfile_wb_pkg`:**
  - `REG_AW`=5, `DATA_W`=32, `NUM_REGS`=32, `ZERO_REG`=0.
  - Typedef `wb_entry_t {addr, data}`.
- **Sub-module `wb_fifo`:** synchronous FIFO of `wb_entry_t` with push/pop/full/empty/count, exposing per-entry valid and address vectors for the QMask compare.
- **Top level:** selection logic, QMask/`Pending` generation, output register.

## Test plan
- **Reset:** release `Reset_n` with no traffic → `RegWrite`=0, `Count`=0, `Pending`=0, `AReady`=`BReady`=1.
- **A-only write:** A writes r2=42 at edge N → `RegWrite`=1, `WriteRegister`=2, `WriteData`=42 in cycle N+1; regfile read of r2 returns 42 after edge N+1.
- **Simultaneous A and B:** A r5=15 and B r6=17 in the same cycle → r5 written at N+1, r6 at N+2 from the FIFO; `Pending[6]`=1 during N+1 and N+2.
- **Write-after-write hold-off:** queue B r7=1 behind A traffic, then present A r7=2 → `AReady`=0 until r7=1 has drained; final r7 read=2.
- **Full FIFO:** fill the FIFO with 4 B entries while A streams → `BReady`=0 and `AReady`=0 at `Count`=4; 4 drain cycles then `Count`=0 with order preserved.
- **Register 0 and mid-operation reset:**
  - A or B to r0=15 → accepted, `RegWrite` stays 0, r0 reads 0.
  - Assert `Reset_n` low with `Count`=3 → `Count`=0 and `RegWrite`=0 immediately; no queued write reaches the regfile.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The FIFO entry is one pending write: a destination register and its data.
package regfile_wb_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot register mask used to build the pending-write vector.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Load-result FIFO for the write-back arbiter. Pointers carry one extra bit so
// that full and empty are distinguished when the index bits are equal. A
// per-slot valid bit and the slot addresses are exported so the arbiter can
// build the mask of registers that still have a queued write.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  wb_entry_t                     din,
    output wb_entry_t                     dout,
    output logic                          full,
    output logic                          empty,
    output logic [CW-1:0]                 count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_addr
);

    wb_entry_t        mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_idx];

    // Overflowing pushes and underflowing pops are ignored so the pointers
    // can never cross, whatever the caller does.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and slot-valid bookkeeping; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_valid <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr              <= rd_ptr + 1'b1;
                entry_valid[rd_idx] <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr              <= wr_ptr + 1'b1;
                entry_valid[wr_idx] <= 1'b1;
            end
        end
    end

    // Storage array; contents are qualified by entry_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_idx] <= din;
        end
    end

    // Expose each slot's destination register for the hazard mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter owning the single register-file write port. The ALU
// (source A) has priority; load results (source B) queue in a small FIFO and
// drain whenever A does not claim the port. A registered output stage drives
// the regfile, and Pending flags every register with a write still in flight
// so decode can stall on read-after-write hazards.
//
// Handshake: a transfer on either source happens at a rising edge where
// valid and ready are both high. Ready is a function of internal state (and
// AReg for source A) only, never of valid. A source holds its payload stable
// from raising valid until the transfer.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         AValid,
    output logic                         AReady,
    input  logic [REG_AW-1:0]            AReg,
    input  logic [DATA_W-1:0]            AData,
    input  logic                         BValid,
    output logic                         BReady,
    input  logic [REG_AW-1:0]            BReg,
    input  logic [DATA_W-1:0]            BData,
    output logic [REG_AW-1:0]            WriteRegister,
    output logic [DATA_W-1:0]            WriteData,
    output logic                         RegWrite,
    output logic [NUM_REGS-1:0]          Pending,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    wb_entry_t                     push_entry;
    wb_entry_t                     head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [DEPTH-1:0]              slot_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  slot_addr;
    logic [NUM_REGS-1:0]           qmask;

    logic                          a_fire;
    logic                          b_fire;
    logic                          a_live;
    logic                          b_live;
    logic                          bypass;
    logic                          push;
    logic                          pop;

    logic                          nxt_we;
    logic [REG_AW-1:0]             nxt_reg;
    logic [DATA_W-1:0]             nxt_data;

    wb_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .push        (push),
        .pop         (pop),
        .din         (push_entry),
        .dout        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (Count),
        .entry_valid (slot_valid),
        .entry_addr  (slot_addr)
    );

    // Mask of registers that still have a load sitting in the FIFO.
    always_comb begin
        qmask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                qmask[slot_addr[i]] = 1'b1;
            end
        end
    end

    // A is held off while an older load to the same register is queued, so
    // the two writes can never land in the wrong order.
    assign BReady = !fifo_full;
    assign AReady = !fifo_full && !qmask[AReg];

    assign a_fire = AValid && AReady;
    assign b_fire = BValid && BReady;

    // Writes to register 0 are accepted and then dropped.
    assign a_live = (AReg != ZERO_REG);
    assign b_live = (BReg != ZERO_REG);

    // An accepted A owns the port, even when it targets register 0 and
    // therefore produces no write. Otherwise the queue head goes first, and a
    // load only skips the FIFO when nothing older is waiting.
    assign pop    = !a_fire && !fifo_empty;
    assign bypass = b_fire && !a_fire && fifo_empty;
    assign push   = b_fire && b_live && !bypass;

    assign push_entry = '{addr: BReg, data: BData};

    // Pick the source for next cycle's regfile write.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_reg  = WriteRegister;
        nxt_data = WriteData;
        if (a_fire) begin
            nxt_we   = a_live;
            nxt_reg  = AReg;
            nxt_data = AData;
        end else if (!fifo_empty) begin
            nxt_we   = 1'b1;
            nxt_reg  = head.addr;
            nxt_data = head.data;
        end else if (b_fire) begin
            nxt_we   = b_live;
            nxt_reg  = BReg;
            nxt_data = BData;
        end
    end

    // Output stage; address and data hold their last values on idle cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= nxt_we;
            if (nxt_we) begin
                WriteRegister <= nxt_reg;
                WriteData     <= nxt_data;
            end
        end
    end

    // Pending covers both queued loads and the write in the output stage.
    always_comb begin
        Pending = qmask;
        if (RegWrite) begin
            Pending = qmask | reg_onehot(WriteRegister);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int W      = REG_AW + DATA_W;

    // ---------------------------------------------------------------- clock/reset
    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;
    always #5 Clk = ~Clk;

    logic              AValid = 1'b0;
    logic [REG_AW-1:0] AReg   = '0;
    logic [DATA_W-1:0] AData  = '0;
    logic              BValid = 1'b0;
    logic [REG_AW-1:0] BReg   = '0;
    logic [DATA_W-1:0] BData  = '0;
    logic              AReady;
    logic              BReady;
    logic [REG_AW-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [31:0]       Pending;
    logic [CW-1:0]     Count;

    regfile_wb_arbiter #(
        .DEPTH         (DEPTH),
        .DATA_W        (DATA_W),
        .REG_AW        (REG_AW)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .AValid        (AValid),
        .AReady        (AReady),
        .AReg          (AReg),
        .AData         (AData),
        .BValid        (BValid),
        .BReady        (BReady),
        .BReg          (BReg),
        .BData         (BData),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .Pending       (Pending),
        .Count         (Count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // exp_q holds the queued loads as {reg, data}, oldest first.
    logic [W-1:0]      exp_q[$];
    logic              exp_we    = 1'b0;
    logic [REG_AW-1:0] exp_wreg  = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic [DATA_W-1:0] rf_ref [32];
    logic [DATA_W-1:0] rf_dut [32];

    function automatic bit q_has(input logic [REG_AW-1:0] r);
        foreach (exp_q[i]) begin
            if (exp_q[i][W-1:DATA_W] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_b_ready();
        return exp_q.size() < DEPTH;
    endfunction

    function automatic bit exp_a_ready();
        return (exp_q.size() < DEPTH) && !q_has(AReg);
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] m;
        m = '0;
        foreach (exp_q[i]) m[exp_q[i][W-1:DATA_W]] = 1'b1;
        if (exp_we) m[exp_wreg] = 1'b1;
        return m;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin : model_step
        bit           af;
        bit           bf;
        logic [W-1:0] hd;
        if (!Reset_n) begin
            exp_q.delete();
            exp_we    = 1'b0;
            exp_wreg  = '0;
            exp_wdata = '0;
        end else begin
            af = AValid && exp_a_ready();
            bf = BValid && exp_b_ready();
            if (exp_we) rf_ref[exp_wreg] = exp_wdata;
            if (af) begin
                exp_we = (AReg != 0);
                if (exp_we) begin
                    exp_wreg  = AReg;
                    exp_wdata = AData;
                end
                if (bf && BReg != 0) exp_q.push_back({BReg, BData});
            end else if (exp_q.size() != 0) begin
                hd        = exp_q.pop_front();
                exp_we    = 1'b1;
                exp_wreg  = hd[W-1:DATA_W];
                exp_wdata = hd[DATA_W-1:0];
                if (bf && BReg != 0) exp_q.push_back({BReg, BData});
            end else if (bf && BReg != 0) begin
                exp_we    = 1'b1;
                exp_wreg  = BReg;
                exp_wdata = BData;
            end else begin
                exp_we = 1'b0;
            end
        end
    end

    // Register file fed by the DUT's write port (r0 stays zero).
    always @(posedge Clk) begin
        if (RegWrite && WriteRegister != 0) rf_dut[WriteRegister] = WriteData;
    end

    // ---------------------------------------------------------------- scoreboard
    always @(negedge Clk) begin
        check("regwrite", RegWrite, exp_we);
        check("wreg", WriteRegister, exp_wreg);
        check("wdata", WriteData, exp_wdata);
        check("count", Count, exp_q.size());
        check("pending", Pending, exp_pending());
        check("aready", AReady, exp_a_ready());
        check("bready", BReady, exp_b_ready());
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic set_in(input bit av, input logic [REG_AW-1:0] ar, input logic [DATA_W-1:0] ad,
                          input bit bv, input logic [REG_AW-1:0] br, input logic [DATA_W-1:0] bd);
        AValid = av; AReg = ar; AData = ad;
        BValid = bv; BReg = br; BData = bd;
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic step(input bit av, input logic [REG_AW-1:0] ar, input logic [DATA_W-1:0] ad,
                        input bit bv, input logic [REG_AW-1:0] br, input logic [DATA_W-1:0] bd);
        set_in(av, ar, ad, bv, br, bd);
        tick();
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit                av;
        bit                bv;
        bit                a_taken;
        bit                b_taken;
        logic [REG_AW-1:0] ar;
        logic [REG_AW-1:0] br;
        logic [DATA_W-1:0] ad;
        logic [DATA_W-1:0] bd;

        for (int i = 0; i < 32; i++) begin
            rf_ref[i] = '0;
            rf_dut[i] = '0;
        end

        #1 Reset_n = 1'b0;
        #20 Reset_n = 1'b1;
        tick();

        // reset state
        check("rst_regwrite", RegWrite, 0);
        check("rst_count", Count, 0);
        check("rst_pending", Pending, 0);
        check("rst_aready", AReady, 1);
        check("rst_bready", BReady, 1);

        // A-only write r2=42
        step(1, 2, 42, 0, 0, 0);
        check("a_only_we", RegWrite, 1);
        check("a_only_reg", WriteRegister, 2);
        check("a_only_data", WriteData, 42);
        idle(1);
        check("a_only_rf", rf_dut[2], 42);

        // simultaneous A r5=15 and B r6=17
        step(1, 5, 15, 1, 6, 17);
        check("sim_reg_a", WriteRegister, 5);
        check("sim_pend6_n1", Pending[6], 1);
        check("sim_count", Count, 1);
        idle(1);
        check("sim_reg_b", WriteRegister, 6);
        check("sim_data_b", WriteData, 17);
        check("sim_pend6_n2", Pending[6], 1);
        idle(1);
        check("sim_pend_clear", Pending, 0);
        check("sim_rf5", rf_dut[5], 15);
        check("sim_rf6", rf_dut[6], 17);

        // write-after-write hold-off on r7
        step(1, 3, 30, 1, 7, 1);
        step(1, 4, 40, 1, 8, 5);
        set_in(1, 7, 2, 0, 0, 0);
        #1 check("waw_blocked", AReady, 0);
        tick();
        check("waw_released", AReady, 1);
        tick();
        idle(4);
        check("waw_rf7", rf_dut[7], 2);
        check("waw_rf8", rf_dut[8], 5);

        // full FIFO while A streams
        for (int i = 0; i < 4; i++) step(1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'(100 + i));
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        check("full_count", Count, 4);
        check("full_aready", AReady, 0);
        check("full_bready", BReady, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_we", RegWrite, 1);
            check("drain_reg", WriteRegister, 20 + i);
            check("drain_data", WriteData, 100 + i);
        end
        check("drain_count", Count, 0);

        // register 0 is accepted and discarded
        step(1, 0, 15, 0, 0, 0);
        check("r0_a_we", RegWrite, 0);
        check("r0_a_pend", Pending, 0);
        step(0, 0, 0, 1, 0, 15);
        check("r0_b_we", RegWrite, 0);
        check("r0_b_count", Count, 0);
        step(1, 0, 15, 1, 0, 15);
        check("r0_ab_we", RegWrite, 0);
        check("r0_ab_count", Count, 0);
        check("r0_rf", rf_dut[0], 0);

        // reset mid-operation with three queued loads
        for (int i = 0; i < 3; i++) step(1, 5'(11 + i), 32'(50 + i), 1, 5'(24 + i), 32'(200 + i));
        set_in(0, 0, 0, 0, 0, 0);
        #1 check("mid_count_before", Count, 3);
        #1 Reset_n = 1'b0;
        #1;
        check("mid_count", Count, 0);
        check("mid_regwrite", RegWrite, 0);
        check("mid_pending", Pending, 0);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        tick();
        idle(3);
        for (int i = 0; i < 3; i++) check("mid_rf_untouched", rf_dut[24 + i], 0);

        // randomized traffic; payload only changes once the offer is taken
        av = 0; bv = 0; a_taken = 0; b_taken = 0;
        ar = '0; br = '0; ad = '0; bd = '0;
        repeat (600) begin
            if (!av || a_taken) begin
                av = ($urandom_range(0, 99) < 60);
                ar = 5'($urandom_range(0, 9));
                ad = $urandom;
            end
            if (!bv || b_taken) begin
                bv = ($urandom_range(0, 99) < 45);
                br = 5'($urandom_range(0, 9));
                bd = $urandom;
            end
            set_in(av, ar, ad, bv, br, bd);
            @(negedge Clk);
            a_taken = AValid && AReady;
            b_taken = BValid && BReady;
            @(posedge Clk);
            #2;
        end
        idle(10);
        check("final_count", Count, 0);
        for (int i = 0; i < 32; i++) check("final_rf", rf_dut[i], rf_ref[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
